// File: rtl/arb_pkg.sv
// Shared types and helpers for the packet-locked round-robin arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    // Widest request vector the reference helper below accepts.
    localparam int unsigned RR_MAX_N = 64;

    // Reference round-robin pick: first set bit of req at or after (last + 1) mod n,
    // with wrap-around. Returns (last + 1) mod n when nothing is requesting.
    function automatic int unsigned rr_next_idx(input logic [RR_MAX_N-1:0] req,
                                                input int unsigned         last,
                                                input int unsigned         n);
        int unsigned idx;
        int unsigned found;
        found = (last + 1) % n;
        // Walk offsets from furthest to nearest so the nearest requester wins.
        for (int k = int'(n); k >= 1; k--) begin
            idx = (last + k) % n;
            if (req[idx]) begin
                found = idx;
            end
        end
        return found;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: grants the first requester after last_idx.
module rr_pick #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last_idx,
    output logic [N-1:0]   grant_onehot,
    output logic [IDW-1:0] grant_idx,
    output logic           any
);

    logic [IDW-1:0] start_idx;
    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    logic [IDW-1:0] offset;
    logic [IDW:0]   sum;

    // Rotate so the slot after last_idx lands on bit 0, then priority-encode the lowest bit.
    always_comb begin
        if (last_idx >= IDW'(N - 1)) begin
            start_idx = '0;
        end else begin
            start_idx = last_idx + IDW'(1);
        end

        req_dbl = {req, req};
        req_rot = req_dbl[start_idx +: N];

        offset = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                offset = IDW'(i);
            end
        end

        // Undo the rotation: index = (start + offset) mod N.
        sum = {1'b0, start_idx} + {1'b0, offset};
        if (sum >= (IDW + 1)'(N)) begin
            sum = sum - (IDW + 1)'(N);
        end
        grant_idx    = sum[IDW-1:0];
        any          = |req;
        grant_onehot = any ? (N'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/rr_pkt_arbiter.sv
// Packet-locked round-robin arbiter: one owner at a time drives the downstream stream
// until its last beat is accepted; the pointer then moves past that owner.
module rr_pkt_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned N         = 4,
    parameter int unsigned DW        = 32,
    parameter int unsigned MAX_BEATS = 16,
    parameter int unsigned IDW       = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    s_valid,
    input  logic [N*DW-1:0] s_data,
    input  logic [N-1:0]    s_last,
    output logic [N-1:0]    s_ready,
    output logic            m_valid,
    output logic [DW-1:0]   m_data,
    output logic            m_last,
    output logic [IDW-1:0]  m_id,
    input  logic            m_ready,
    output logic            busy,
    output logic            len_err
);

    localparam int unsigned CW = $clog2(MAX_BEATS + 1);

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] sel_q, sel_d;
    logic [IDW-1:0] last_q, last_d;
    logic [CW-1:0]  beat_cnt_q, beat_cnt_d;
    logic           len_err_q, len_err_d;

    logic [N-1:0]   pick_onehot;
    logic [IDW-1:0] pick_idx;
    logic           pick_any;
    logic           xfer;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req          (s_valid),
        .last_idx     (last_q),
        .grant_onehot (pick_onehot),
        .grant_idx    (pick_idx),
        .any          (pick_any)
    );

    assign xfer = m_valid & m_ready;

    // State, pointer and beat-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            last_q     <= IDW'(N - 1);
            beat_cnt_q <= '0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
            beat_cnt_q <= beat_cnt_d;
            len_err_q  <= len_err_d;
        end
    end

    // Next state: arbitrate in IDLE, hold the lock until the owner's last beat moves.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_d     = last_q;
        beat_cnt_d = beat_cnt_q;
        len_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d    = LOCK;
                    sel_d      = pick_idx;
                    beat_cnt_d = '0;
                end
            end
            LOCK: begin
                if (xfer) begin
                    if (m_last) begin
                        last_d     = sel_q;
                        state_d    = IDLE;
                        beat_cnt_d = '0;
                    end else begin
                        // Counter saturates, so this fires at most once per packet.
                        if (beat_cnt_q == CW'(MAX_BEATS - 1)) begin
                            len_err_d = 1'b1;
                        end
                        if (beat_cnt_q != CW'(MAX_BEATS)) begin
                            beat_cnt_d = beat_cnt_q + CW'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: combinational mux from the owner while locked, everything quiet otherwise.
    always_comb begin
        s_ready = '0;
        m_valid = 1'b0;
        m_data  = '0;
        m_last  = 1'b0;
        m_id    = '0;
        busy    = (state_q == LOCK);
        len_err = len_err_q;
        if (state_q == LOCK) begin
            m_valid        = s_valid[sel_q];
            m_data         = s_data[sel_q*DW +: DW];
            m_last         = s_last[sel_q];
            m_id           = sel_q;
            s_ready[sel_q] = m_ready;
        end
    end

    a_ready_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(s_ready));
    a_busy_lock : assert property (@(posedge clk) disable iff (!rst_n)
        busy |-> (state_q == LOCK));
    a_stall_hold : assert property (@(posedge clk) disable iff (!rst_n)
        (m_valid && !m_ready) |=> $stable(state_q));
    a_pick_consistent : assert property (@(posedge clk) disable iff (!rst_n)
        pick_any |-> (pick_onehot[pick_idx] && $onehot(pick_onehot)));

endmodule

// File: doc/rr_pkt_arbiter.md
Name: rr_pkt_arbiter

Overview:
Packet-locked round-robin arbiter that shares one downstream valid/ready stream port between N upstream requesters. It picks a winner among requesters with s_valid high and locks the grant until that requester's last beat is accepted. It then advances the round-robin pointer past the winner. It sits in front of any shared sink, such as a link or FIFO, that must not see interleaved packets.

Parameters:
N, 4, number of requesters (N >= 1)
DW, 32, data width per beat
MAX_BEATS, 16, beat count above which a packet is flagged over-length (>= 1)
IDW, $clog2(N) (min 1), width of m_id

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
s_valid  in  N  per-requester beat valid
s_data  in  N*DW  per-requester beat data, requester i in bits [i*DW +: DW]
s_last  in  N  per-requester last beat of packet
s_ready  out  N  per-requester beat accepted when s_valid[i] & s_ready[i]
m_valid  out  1  downstream beat valid
m_data  out  DW  downstream data
m_last  out  1  downstream last beat
m_id  out  IDW  index of the current owner
m_ready  in  1  downstream ready
busy  out  1  grant locked (state LOCK)
len_err  out  1  one-cycle pulse on over-length packet

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE, sel_q=0, last_q=N-1 (requester 0 has first priority), beat_cnt=0.
  - Outputs: s_ready=0, m_valid=0, m_last=0, m_id=0, busy=0, len_err=0.
  - Reset mid-packet abandons the packet with no recovery beat.
- States: IDLE, LOCK.
- IDLE:
  - s_ready=0, m_valid=0.
  - If |s_valid: winner = first i with s_valid[i] set, searching from (last_q+1) mod N upward with wrap-around.
  - Next cycle: sel_q=winner, state=LOCK, beat_cnt=0.
  - If s_valid==0: stay in IDLE.
- LOCK:
  - Combinational mux: m_valid=s_valid[sel_q], m_data=s_data[sel_q], m_last=s_last[sel_q], m_id=sel_q.
  - s_ready[sel_q]=m_ready; all other s_ready bits are 0.
  - Non-owners are never accepted, regardless of their s_valid.
  - Transfer = m_valid & m_ready.
  - On a transfer with m_last=1: last_q<=sel_q, state<=IDLE, beat_cnt<=0.
  - On a transfer with m_last=0: beat_cnt increments, saturating at MAX_BEATS.
  - Owner dropping s_valid mid-packet is a bubble: grant stays locked, no timeout.
  - Owner dropping s_valid between the IDLE decision and LOCK: still locked; wait for its beats.
- Latency and throughput:
  - Arbitration takes 1 cycle (the IDLE cycle); the first beat of the winner can transfer in the first LOCK cycle.
  - Exactly one dead cycle between packets, so a single-beat packet stream runs at 50% throughput. This is an accepted cost.
- Data path is combinational from s_* to m_* during LOCK; m_ready reaches s_ready combinationally. There are no registers in the data path.
- len_err: pulses for 1 cycle on a transfer with m_last=0 while beat_cnt==MAX_BEATS-1, i.e. the packet reaches MAX_BEATS+1 beats. It pulses once per packet; the lock is kept. beat_cnt width is $clog2(MAX_BEATS+1).
- Fairness: with all requesters continuously valid, the grant order is 0,1,...,N-1,0,...; each requester waits at most N-1 packets.
- Simultaneous events: a new s_valid in the same cycle as the owner's last beat is not considered until the following IDLE cycle.
- N=1: the pointer is constant, m_id=0, and the IDLE bubble still applies.
- Assertions:
  - $onehot0(s_ready).
  - busy implies state==LOCK.
  - No state change while m_valid & !m_ready, unless in reset.

Decomposition:
- Package arb_pkg:
  - arb_state_e enum {IDLE, LOCK}.
  - Function rr_next_idx(req, last, N) for model/scoreboard reuse.
- Sub-module rr_pick (combinational, parameter N):
  - Inputs: req[N], last_idx.
  - Outputs: grant_onehot[N], grant_idx, any.
  - Implementation: double-width rotate and priority encode.
  - Reusable by other arbiters in the codebase.
- Top level holds the FSM, pointer, beat counter and output mux.

Test Plan:
- Reset, then s_valid=4'b0000 for 10 cycles -> m_valid=0, s_ready=0, busy=0, m_id=0 throughout.
- All four requesters valid, each with 2-beat packets, m_ready=1 -> m_id sequence 0,0,1,1,2,2,3,3,0 with one m_valid=0 cycle between packets; s_ready $onehot0 every cycle.
- Owner 2 mid-packet with m_ready toggling 1,0,0,1 and s_valid[2] dropping for 2 cycles, req 0 also valid -> grant stays on 2, m_data stable while stalled, s_ready[0]=0 until 2's last beat, then m_id=3 is skipped (not valid) and 0 is granted.
- last_q=1, s_valid=4'b0011 -> 0 is granted (wrap-around); next packet goes to 1.
- MAX_BEATS=4, 6-beat packet from requester 1 -> len_err pulses exactly once, on beat 5; the packet completes and the grant moves on normally.
- Assert rst_n low in the middle of a LOCK transfer -> s_ready=0 and m_valid=0 immediately (async); after release, requester 0 has first priority.
